// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M multiply/divide sequencer. MUL goes through the shared ALU multiplier; MULH* and div/rem use a 32-step iterative datapath.
// Latency: 1 cycle for div-by-zero/overflow, 1 + grant wait for MUL, 34 for iterative ops. done is a 1-cycle pulse; busy holds the pipeline.
// Backpressure: MUL waits indefinitely for alu_gnt, and start is ignored while busy. Optional MULDIV_FLUSH_EN adds a flush abort port.
module muldiv_seq #(
    parameter int         XLEN        = 32,
    parameter logic [6:0] ALU_MUL_SEL = 7'd10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [6:0]      alu_s,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
`ifdef MULDIV_FLUSH_EN
    input  logic            flush,
`endif
    input  logic [XLEN-1:0] alu_mul_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALU_WAIT,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                neg_a, neg_b;
    logic [2*XLEN-1:0]   acc;
    logic [4:0]          cnt;
    logic [XLEN-1:0]     result_q;
    logic                flush_hit;

`ifdef MULDIV_FLUSH_EN
    assign flush_hit = flush && (state_q != S_IDLE);
`else
    assign flush_hit = 1'b0;
`endif

    // ---------------- start decode ----------------
    logic            a_signed, b_signed, sa, sb;
    logic            div_zero, div_ovf, corner;
    logic [XLEN-1:0] corner_res, a_abs, b_abs;

    always_comb begin
        a_signed   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa         = a_signed && a[XLEN-1];
        sb         = b_signed && b[XLEN-1];
        // 33-bit negation keeps the 0x80000000 magnitude intact
        a_abs      = sa ? XLEN'(33'd0 - {a[XLEN-1], a}) : a;
        b_abs      = sb ? XLEN'(33'd0 - {b[XLEN-1], b}) : b;
        div_zero   = op[2] && (b == '0);
        div_ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
                     (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        corner     = div_zero || div_ovf;
        corner_res = '0;
        if (div_zero)
            corner_res = op[1] ? a : 32'hFFFF_FFFF;
        else if (div_ovf)
            corner_res = op[1] ? 32'h0 : 32'h8000_0000;
    end

    // ---------------- iteration step ----------------
    logic [XLEN:0]     mul_sum, mul_hi, div_rs, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        // multiply: acc = {partial product high, remaining multiplier bits}
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_a};
        mul_hi   = acc[0] ? mul_sum : {1'b0, acc[2*XLEN-1:XLEN]};
        // divide: acc = {partial remainder, dividend bits becoming quotient}
        div_rs   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_rs - {1'b0, mag_b};
        div_ge   = !div_diff[XLEN];
        if (op_q[2])
            acc_next = {(div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]),
                        acc[XLEN-2:0], div_ge};
        else
            acc_next = {mul_hi, acc[XLEN-1:1]};
    end

    // ---------------- sign fix-up ----------------
    logic [XLEN-1:0] fix_res;

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'd4, 3'd5: fix_res = (neg_a ^ neg_b) ?
                                  XLEN'(33'd0 - {1'b0, acc[XLEN-1:0]}) : acc[XLEN-1:0];
            3'd6, 3'd7: fix_res = neg_a ?
                                  XLEN'(33'd0 - {1'b0, acc[2*XLEN-1:XLEN]}) : acc[2*XLEN-1:XLEN];
            default:    fix_res = (neg_a ^ neg_b) ?
                                  XLEN'((64'd0 - acc) >> XLEN) : acc[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        alu_req = 1'b0;
        alu_s   = '0;
        alu_a   = '0;
        alu_b   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL)
                        state_d = S_ALU_WAIT;
                    else if (corner)
                        state_d = S_DONE;
                    else
                        state_d = S_ITER;
                end
            end
            S_ALU_WAIT: begin
                alu_req = 1'b1;
                alu_s   = ALU_MUL_SEL;
                alu_a   = a_q;
                alu_b   = b_q;
                if (alu_gnt)
                    state_d = S_DONE;
            end
            S_ITER:   if (cnt == 5'd31) state_d = S_FIX;
            S_FIX:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (flush_hit)
            state_d = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        mag_a <= a_abs;
                        mag_b <= b_abs;
                        neg_a <= sa;
                        neg_b <= sb;
                        cnt   <= '0;
                        acc   <= {{XLEN{1'b0}}, (op[2] ? a_abs : b_abs)};
                        if (op != OP_MUL && corner)
                            result_q <= corner_res;
                    end
                end
                S_ALU_WAIT: if (alu_gnt && !flush_hit) result_q <= alu_mul_out;
                S_ITER: begin
                    acc <= acc_next;
                    cnt <= cnt + 5'd1;
                end
                S_FIX: if (!flush_hit) result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule
